// File: rtl/int2float_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : int2float_serial_loader
//  Description : Deserializes a framed LSB-first serial stream into WORD_W-bit
//                words and buffers them in a first-word-fall-through FIFO that
//                feeds the integer-to-float converter over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module int2float_serial_loader #(
  parameter int WORD_W = 11,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ser_vld,
  input  logic                       ser_sof,
  input  logic                       ser_bit,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overrun,
  output logic                       frame_err
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WORD_W-1:0]   r_shreg;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [FILL_W-1:0]   r_fill;
  logic                r_overrun;
  logic                r_frame_err;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_accept;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   w_restart;

  // The bit landing in the top position completes the word; it goes straight
  // into the FIFO on the same edge, so the assembled word is built from the
  // live serial bit rather than the shift register.
  assign w_push    = (r_state == S_SHIFT) && ser_vld && !ser_sof &&
                     (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign w_word    = {ser_bit, r_shreg[WORD_W-2:0]};
  assign w_restart = {{(WORD_W-1){1'b0}}, ser_bit};

  // A push into a full FIFO is still accepted when the head leaves on the
  // same edge, since the freed slot is exactly the one being written.
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_fill == FILL_W'(DEPTH));
  assign w_accept  = w_push && (!w_full || w_pop);

  assign out_valid  = (r_fill != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign fill_level = r_fill;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

  // Frame deserializer FSM with registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= w_push && !w_accept;
      case (r_state)
        S_IDLE: begin
          // Bits without a start-of-frame marker are silently ignored here.
          if (ser_vld && ser_sof) begin
            r_shreg   <= w_restart;
            r_bit_cnt <= CNT_W'(1);
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_vld) begin
            if (ser_sof) begin
              r_frame_err <= 1'b1;
              r_shreg     <= w_restart;
              r_bit_cnt   <= CNT_W'(1);
            end else if (w_push) begin
              r_shreg   <= '0;
              r_bit_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_shreg[r_bit_cnt] <= ser_bit;
              r_bit_cnt          <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  // FWFT FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int2float_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int2float_serial_loader
//  Description : Self-checking bench for int2float_serial_loader. Expected
//                words are queued as frames are driven and compared as the
//                FIFO hands them out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int2float_serial_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_vld = 1'b0;
  logic        ser_sof = 1'b0;
  logic        ser_bit = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] out_data;
  logic        out_valid;
  logic [2:0]  fill_level;
  logic        overrun;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_ovr    = 0;
  int n_ferr   = 0;
  logic [10:0] q [$];

  typedef struct {
    logic [10:0] word;
    int          gap;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl [4];

  int2float_serial_loader #(.WORD_W(11), .DEPTH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_vld    (ser_vld),
    .ser_sof    (ser_sof),
    .ser_bit    (ser_bit),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every word handed out must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun)   n_ovr++;
      if (frame_err) n_ferr++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", int'(out_data), -1);
        end else begin
          check("sb_data", int'(out_data), int'(q.pop_front()));
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic sof);
    @(posedge clk); #1;
    ser_vld = 1'b1; ser_sof = sof; ser_bit = b;
  endtask

  task automatic idle_slot();
    @(posedge clk); #1;
    ser_vld = 1'b0; ser_sof = 1'b0; ser_bit = 1'($urandom);
  endtask

  task automatic send_frame(input logic [10:0] w, input int gap);
    for (int i = 0; i < 11; i++) begin
      send_bit(w[i], i == 0);
      if (i != 10) repeat (gap) idle_slot();
    end
    idle_slot();
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
    check(name, q.size(), 0);
    check({name, "_fill"}, int'(fill_level), 0);
  endtask

  initial begin
    int ovr0, ferr0, g;
    logic [10:0] w;
    tbl[0] = '{11'h000, 0, 11'h000};
    tbl[1] = '{11'h7FF, 0, 11'h7FF};
    tbl[2] = '{11'h555, 1, 11'h555};
    tbl[3] = '{11'h2AA, 2, 11'h2AA};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data), 0);
    check("rst_fill",  int'(fill_level), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ovr",  int'(overrun), 0);
    check("rst_ferr", int'(frame_err), 0);

    // Single frame 0x5A3 with latency check
    out_ready = 1'b1;
    w = 11'h5A3;
    q.push_back(w);
    for (int i = 0; i < 10; i++) send_bit(w[i], i == 0);
    send_bit(w[10], 1'b0);
    @(negedge clk);
    check("lat_before", int'(out_valid), 0);
    idle_slot();
    @(negedge clk);
    check("lat_valid", int'(out_valid), 1);
    check("lat_data",  int'(out_data), 'h5A3);
    @(negedge clk);
    check("lat_after", int'(out_valid), 0);

    // Table-driven frames, one cycle latency each
    for (int t = 0; t < 4; t++) begin
      q.push_back(tbl[t].exp);
      send_frame(tbl[t].word, tbl[t].gap);
      @(negedge clk);
      check("tbl_valid", int'(out_valid), 1);
      check("tbl_data",  int'(out_data), int'(tbl[t].exp));
    end
    wait_drain("tbl_drain");

    // Backpressure fill and overrun
    out_ready = 1'b0;
    ovr0 = n_ovr;
    q.push_back(11'h001); q.push_back(11'h7FF);
    q.push_back(11'h400); q.push_back(11'h155);
    send_frame(11'h001, 0);
    send_frame(11'h7FF, 0);
    send_frame(11'h400, 0);
    send_frame(11'h155, 0);
    send_frame(11'h2AA, 0);
    repeat (3) idle_slot();
    check("bp_fill", int'(fill_level), 4);
    check("bp_head", int'(out_data), 'h001);
    check("bp_ovr",  n_ovr - ovr0, 1);
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Full FIFO with a pop on the completion edge
    out_ready = 1'b0;
    ovr0 = n_ovr;
    q.push_back(11'h011); q.push_back(11'h022);
    q.push_back(11'h033); q.push_back(11'h044);
    q.push_back(11'h0F0);
    send_frame(11'h011, 0);
    send_frame(11'h022, 0);
    send_frame(11'h033, 0);
    send_frame(11'h044, 0);
    w = 11'h0F0;
    for (int i = 0; i < 10; i++) send_bit(w[i], i == 0);
    @(posedge clk); #1;
    ser_vld = 1'b1; ser_sof = 1'b0; ser_bit = w[10]; out_ready = 1'b1;
    @(posedge clk); #1;
    ser_vld = 1'b0; out_ready = 1'b0;
    repeat (2) idle_slot();
    check("sim_fill", int'(fill_level), 4);
    check("sim_ovr",  n_ovr - ovr0, 0);
    out_ready = 1'b1;
    wait_drain("sim_drain");

    // Mid-frame start-of-frame restart
    ovr0 = n_ovr; ferr0 = n_ferr;
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    q.push_back(11'h3C3);
    send_frame(11'h3C3, 0);
    repeat (2) idle_slot();
    check("mid_ferr", n_ferr - ferr0, 1);
    wait_drain("mid_drain");

    // Stray bits while idle, then a frame with random gaps
    ferr0 = n_ferr;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    repeat (3) idle_slot();
    check("stray_fill", int'(fill_level), 0);
    w = 11'h6B9;
    q.push_back(w);
    for (int i = 0; i < 11; i++) begin
      send_bit(w[i], i == 0);
      g = $urandom_range(0, 3);
      if (i != 10) repeat (g) idle_slot();
    end
    idle_slot();
    wait_drain("gap_drain");
    check("gap_ferr", n_ferr - ferr0, 0);
    check("gap_ovr",  n_ovr - ovr0, 0);

    // Asynchronous reset with buffered words and a partial frame
    out_ready = 1'b0;
    send_frame(11'h0AA, 0);
    send_frame(11'h055, 0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, i == 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", int'(out_valid), 0);
    check("ar_data",  int'(out_data), 0);
    check("ar_fill",  int'(fill_level), 0);
    check("ar_ovr",   int'(overrun), 0);
    check("ar_ferr",  int'(frame_err), 0);
    q.delete();
    ser_vld = 1'b0; ser_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    q.push_back(11'h123);
    send_frame(11'h123, 0);
    @(negedge clk);
    check("ar_word", int'(out_data), 'h123);
    wait_drain("ar_drain");
    repeat (5) idle_slot();
    check("end_ovr",  n_ovr - ovr0, 0);
    check("end_ferr", n_ferr - ferr0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int2float_serial_loader.md
Name: int2float_serial_loader

Overview:
- Upstream feeder for the 11-bit integer-to-7-bit-float converter.
- Deserializes a framed 1-bit serial stream, LSB first, into WORD_W-bit integer words.
- Buffers completed words in a small first-word-fall-through FIFO.
- Presents each word on a valid/ready interface whose data drives the converter's integer inputs (bit 0 to input 0, ..., bit 10 to input 10).

Parameters:
- WORD_W, 11, bits per word; must match converter input width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 4, width of bit counter; must satisfy 2^CNT_W > WORD_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ser_vld  in  1  serial bit present this cycle.
- ser_sof  in  1  start of frame; meaningful only when ser_vld=1.
- ser_bit  in  1  serial data bit.
- out_data  out  WORD_W  head-of-FIFO word (to converter).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts word when out_valid=1.
- fill_level  out  $clog2(DEPTH)+1  number of words held.
- overrun  out  1  one-cycle pulse: completed word dropped because FIFO full.
- frame_err  out  1  one-cycle pulse: sof arrived while a frame was partially shifted.

Behaviour:
- Reset (async assert, sync-safe deassert handled externally):
  - FSM=IDLE, bit_cnt=0, shift register=0.
  - FIFO pointers=0, fill_level=0.
  - out_valid=0, out_data=0, overrun=0, frame_err=0.
  - Asserting reset mid-frame discards the partial word and all buffered words.
- FSM states:
  - IDLE: ser_vld & ser_sof → load ser_bit into bit 0, bit_cnt=1, go SHIFT. ser_vld without sof is ignored, with no error.
  - SHIFT: ser_vld & !ser_sof → write ser_bit at position bit_cnt, bit_cnt+1. ser_vld & ser_sof → frame_err pulse next cycle, partial word discarded, restart with this bit as bit 0, bit_cnt=1, stay SHIFT. ser_vld=0 → hold, with no timeout.
  - Completion: the bit written at position WORD_W-1 completes the word. The assembled word is pushed into the FIFO on that same edge, then bit_cnt=0 and FSM=IDLE.
- Push rule:
  - Accepted if fill_level<DEPTH, or if fill_level==DEPTH and a pop occurs on the same edge.
  - Otherwise the word is dropped and overrun pulses high for exactly one cycle after that edge. FIFO contents are unchanged.
- Pop rule: out_valid & out_ready at an edge removes the head entry. out_ready while out_valid=0 has no effect.
- Latency: the last bit sampled at edge N gives out_valid=1 and out_data=word in the cycle after edge N, when the FIFO was empty.
- FWFT: out_data always shows the head entry. out_data holds its last value when empty; it is not required to be zero.
- Ordering: words leave in arrival order. Pointers wrap modulo DEPTH.
- fill_level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- out_valid is a pure function of registered fill_level (!=0). There is no combinational path from out_ready to out_valid.
- frame_err and overrun are registered. They may both pulse in the same cycle only if an sof restart coincides with a drop; that case is impossible, since completion requires !sof.

Test Plan:
- Single frame: sof+11 bits of 0x5A3 LSB first (1,1,0,0,0,1,0,1,1,0,1), out_ready=1 → out_valid high one cycle after the 11th bit, out_data=0x5A3, then out_valid=0.
- Backpressure fill: out_ready=0, send words 0x001,0x7FF,0x400,0x155,0x2AA → fill_level reaches 4. The fifth word is dropped with a 1-cycle overrun pulse. Raising out_ready drains 0x001,0x7FF,0x400,0x155 in order.
- Full with simultaneous pop: FIFO full, out_ready=1 on the completion edge of 0x0F0 → no overrun, fill_level stays 4, 0x0F0 emerges last.
- Mid-frame sof: after 5 bits, assert sof and send 11 bits of 0x3C3 → frame_err pulses once. Only 0x3C3 is output.
- Gaps and stray bits: ser_vld toggling randomly within a frame of 0x6B9, plus ser_vld without sof while IDLE → out_data=0x6B9, no errors, the stray bits produce nothing.
- Reset mid-operation: 2 words buffered plus 6 bits of a partial frame, pulse rst_n low asynchronously → all outputs 0 immediately. A subsequent clean frame 0x123 is the only word output.
